// File: rtl/key_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_scan_pkg
//  Brief    : Shared types, constants and helpers for the key_scan8 keypad
//             scanner (state encoding, matrix geometry, column encoder).
//  Revision : 1.0 - initial release
// ============================================================================
package key_scan_pkg;

    // Scanner state encoding
    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        REPORT  = 2'd2,
        RELEASE = 2'd3
    } ks_state_t;

    localparam int KS_ROWS   = 8;
    localparam int KS_COLS   = 4;
    localparam int KS_ROW_W  = $clog2(KS_ROWS);
    localparam int KS_COL_W  = $clog2(KS_COLS);
    localparam int KS_CODE_W = 5;
    localparam int KS_CNT_W  = 4;

    // Lowest set column index wins; returns 0 when nothing is set.
    function automatic logic [KS_COL_W-1:0] ks_prio4(input logic [KS_COLS-1:0] c);
        logic [KS_COL_W-1:0] idx;
        idx = 2'd0;
        if (c[0])      idx = 2'd0;
        else if (c[1]) idx = 2'd1;
        else if (c[2]) idx = 2'd2;
        else if (c[3]) idx = 2'd3;
        return idx;
    endfunction

    // True when more than one column is set.
    function automatic logic ks_multi(input logic [KS_COLS-1:0] c);
        return (c & (c - 4'd1)) != 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_scan_sync.sv
`default_nettype none
// ============================================================================
//  Module   : key_scan_sync
//  Brief    : Parameterised-width two-flop synchroniser, async active-low
//             reset to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module key_scan_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;

endmodule
`default_nettype wire

// File: rtl/key_scan8.sv
`default_nettype none
// ============================================================================
//  Module   : key_scan8
//  Brief    : 8-row matrix keypad scanner. Drives a binary row index, samples
//             synchronised column returns once per dwell window, debounces
//             press and release, and reports one key code per press over a
//             valid/ready handshake.
//  Config   : define KEY_SCAN_GHOST_EN to treat multi-column samples as
//             "no key" (ghost rejection); default is lowest column wins.
//  Revision : 1.0 - initial release
// ============================================================================
module key_scan8
    import key_scan_pkg::*;
#(
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic [KS_ROW_W-1:0]  row_sel,
    input  logic [KS_COLS-1:0]   col_in,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [KS_CODE_W-1:0] key_code
);

    localparam int DC_W = $clog2(DWELL);
    localparam logic [DC_W-1:0]     C_DC_LAST  = DC_W'(DWELL - 1);
    localparam logic [KS_CNT_W-1:0] C_DEBOUNCE = KS_CNT_W'(DEBOUNCE);
    localparam logic [KS_CNT_W-1:0] C_CNT_ONE  = 4'd1;

    logic [KS_COLS-1:0]   w_col_s;
    ks_state_t            r_state;
    logic [DC_W-1:0]      r_dc;
    logic [KS_CNT_W-1:0]  r_cnt;
    logic [KS_ROW_W-1:0]  r_row;
    logic [KS_CODE_W-1:0] r_code;
    logic                 r_valid;

    logic                 w_sample;
    logic [KS_COL_W-1:0]  w_col;
    logic                 w_hit;
    logic                 w_press;
    logic                 w_cand_set;
    logic                 w_cand_clear;
    logic [KS_CNT_W-1:0]  w_cnt_inc;
    logic                 w_cnt_done;

    key_scan_sync #(
        .WIDTH (KS_COLS)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (col_in),
        .dout  (w_col_s)
    );

    assign w_sample   = (r_dc == C_DC_LAST);
    assign w_col      = ks_prio4(w_col_s);
    assign w_hit      = w_col_s[r_code[KS_COL_W-1:0]];
    assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    assign w_cnt_done = (w_cnt_inc == C_DEBOUNCE);

`ifdef KEY_SCAN_GHOST_EN
    // A multi-column sample is never a valid press and never a clean release
    logic w_multi;
    assign w_multi      = ks_multi(w_col_s);
    assign w_press      = (|w_col_s) && !w_multi;
    assign w_cand_set   = w_hit && !w_multi;
    assign w_cand_clear = !w_hit && !w_multi;
`else
    assign w_press      = |w_col_s;
    assign w_cand_set   = w_hit;
    assign w_cand_clear = !w_hit;
`endif

    // Scan / debounce / report / release sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN;
            r_dc    <= '0;
            r_cnt   <= '0;
            r_row   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (en) begin
                        if (w_sample) begin
                            r_dc <= '0;
                            if (w_press) begin
                                r_code <= {r_row, w_col};
                                r_cnt  <= C_CNT_ONE;
                                if (C_CNT_ONE == C_DEBOUNCE) begin
                                    r_state <= REPORT;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_state <= CONFIRM;
                                end
                            end else begin
                                r_row <= r_row + 3'd1;
                            end
                        end else begin
                            r_dc <= r_dc + DC_W'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (w_sample) begin
                        r_dc <= '0;
                        if (w_cand_set) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_state <= REPORT;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            // Bounce or ghost: abandon and move on to the next row
                            r_state <= SCAN;
                            r_cnt   <= '0;
                            r_row   <= r_row + 3'd1;
                        end
                    end else begin
                        r_dc <= r_dc + DC_W'(1);
                    end
                end
                REPORT: begin
                    r_dc <= '0;
                    if (r_valid && key_ready) begin
                        r_state <= RELEASE;
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                RELEASE: begin
                    if (w_sample) begin
                        r_dc <= '0;
                        if (w_cand_clear) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_done) begin
                                r_state <= SCAN;
                                r_cnt   <= '0;
                                r_row   <= r_row + 3'd1;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end else begin
                        r_dc <= r_dc + DC_W'(1);
                    end
                end
                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

    assign row_sel   = r_row;
    assign key_valid = r_valid;
    assign key_code  = r_code;

endmodule
`default_nettype wire

// File: tb/tb_key_scan8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_scan8
//  Brief    : Directed self-checking bench for key_scan8 (DWELL=4,
//             DEBOUNCE=3) with a combinational keypad matrix model.
//  Config   : expectations follow KEY_SCAN_GHOST_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_scan8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] row_sel;
    logic [3:0] col_in;
    logic       key_valid;
    logic       key_ready;
    logic [4:0] key_code;

    logic       kp_on;
    logic [2:0] kp_row;
    logic [3:0] kp_mask;

    int vecs;
    int miscompares;

    key_scan8 #(
        .DWELL    (4),
        .DEBOUNCE (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .row_sel   (row_sel),
        .col_in    (col_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code)
    );

    // Keypad matrix: a pressed key returns its columns only while its row is driven
    assign col_in = (kp_on && (row_sel == kp_row)) ? kp_mask : 4'b0000;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        en          = 1'b0;
        key_ready   = 1'b0;
        kp_on       = 1'b0;
        kp_row      = 3'd0;
        kp_mask     = 4'b0000;

        // Reset state
        tick(3);
        chk("rst_row", {5'b0, row_sel}, 8'd0);
        chk("rst_valid", {7'b0, key_valid}, 8'd0);
        chk("rst_code", {3'b0, key_code}, 8'd0);

        // Idle scan: one row step every 4 cycles, full wrap
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(3);
            chk("idle_row_hold", {5'b0, row_sel}, 8'((i - 1) % 8));
            chk("idle_valid", {7'b0, key_valid}, 8'd0);
            tick(1);
            chk("idle_row_step", {5'b0, row_sel}, 8'(i % 8));
        end

        // Clean press on row 5, column 2, with back-pressure
        kp_row  = 3'd5;
        kp_mask = 4'b0100;
        kp_on   = 1'b1;
        tick(31);
        chk("press_early", {7'b0, key_valid}, 8'd0);
        tick(1);
        chk("press_valid", {7'b0, key_valid}, 8'd1);
        chk("press_code", {3'b0, key_code}, 8'h16);
        chk("press_row", {5'b0, row_sel}, 8'd5);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_valid", {7'b0, key_valid}, 8'd1);
            chk("bp_code", {3'b0, key_code}, 8'h16);
        end
        key_ready = 1'b1;
        tick(1);
        chk("ack_valid_low", {7'b0, key_valid}, 8'd0);
        key_ready = 1'b0;

        // Key held 40 cycles after acknowledge, then released
        tick(39);
        chk("held_row", {5'b0, row_sel}, 8'd5);
        chk("held_no_rereport", {7'b0, key_valid}, 8'd0);
        tick(1);
        kp_on = 1'b0;
        tick(11);
        chk("rel_row_hold", {5'b0, row_sel}, 8'd5);
        tick(1);
        chk("rel_row_next", {5'b0, row_sel}, 8'd6);
        chk("rel_valid", {7'b0, key_valid}, 8'd0);

        // Bounce: row 3 key visible for exactly one sample
        tick(20);
        chk("bnc_row3", {5'b0, row_sel}, 8'd3);
        kp_row  = 3'd3;
        kp_mask = 4'b0001;
        kp_on   = 1'b1;
        tick(4);
        kp_on = 1'b0;
        chk("bnc_confirm_hold", {5'b0, row_sel}, 8'd3);
        tick(4);
        chk("bnc_abort_row", {5'b0, row_sel}, 8'd4);
        chk("bnc_valid", {7'b0, key_valid}, 8'd0);

        // Multi-key on row 2, ready already high before valid
        kp_row    = 3'd2;
        kp_mask   = 4'b1010;
        kp_on     = 1'b1;
        key_ready = 1'b1;
        tick(36);
`ifdef KEY_SCAN_GHOST_EN
        chk("ghost_valid", {7'b0, key_valid}, 8'd0);
        chk("ghost_row", {5'b0, row_sel}, 8'd5);
        tick(1);
        chk("ghost_valid2", {7'b0, key_valid}, 8'd0);
`else
        chk("multi_valid", {7'b0, key_valid}, 8'd1);
        chk("multi_code", {3'b0, key_code}, 8'h09);
        tick(1);
        chk("multi_one_cycle", {7'b0, key_valid}, 8'd0);
`endif
        key_ready = 1'b0;
        kp_on     = 1'b0;
        rst_n     = 1'b0;
        tick(1);
        chk("rst2_row", {5'b0, row_sel}, 8'd0);
        rst_n = 1'b1;
        en    = 1'b0;

        // en low in SCAN holds the row
        tick(6);
        chk("en_hold_row", {5'b0, row_sel}, 8'd0);

        // en dropped during CONFIRM: report still completes
        kp_row  = 3'd1;
        kp_mask = 4'b1000;
        kp_on   = 1'b1;
        en      = 1'b1;
        tick(8);
        chk("enc_row", {5'b0, row_sel}, 8'd1);
        chk("enc_code", {3'b0, key_code}, 8'h07);
        chk("enc_valid_early", {7'b0, key_valid}, 8'd0);
        en = 1'b0;
        tick(8);
        chk("enc_valid", {7'b0, key_valid}, 8'd1);
        chk("enc_code2", {3'b0, key_code}, 8'h07);

        // Asynchronous reset during REPORT
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {7'b0, key_valid}, 8'd0);
        chk("arst_row", {5'b0, row_sel}, 8'd0);
        chk("arst_code", {3'b0, key_code}, 8'd0);
        tick(1);
        rst_n = 1'b1;
        kp_on = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
